// File: rtl/alu_share_if.sv
// Request/response/ALU bundle between the two requesters, the shared ALU and the arbiter.
interface alu_share_if #(parameter int DATA_W = 32);
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_in1, req0_in2;
  logic [3:0]        req0_op;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_in1, req1_in2;
  logic [3:0]        req1_op;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
  logic [3:0]        alu_op;

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_op,
    output req1_valid, req1_in1, req1_in2, req1_op,
    output rsp_ready, alu_out,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  alu_in1, alu_in2, alu_op
  );

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_op,
    input  req1_valid, req1_in1, req1_in2, req1_op,
    input  rsp_ready, alu_out,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output alu_in1, alu_in2, alu_op
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one combinational ALU: accept -> EXEC -> RESP,
// one tagged registered response per accepted request.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1,
  parameter int OP_MAX = 9
) (
  input logic       clk,
  input logic       rst_n,
  alu_share_if.slave bus
);
  localparam logic [3:0] OP_LIM = 4'(OP_MAX);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [3:0]        op;
  } req_t;

  state_t            state;
  logic              last_grant, gnt, id_q, op_bad;
  logic [1:0]        vld, rdy;
  req_t              req [2];
  req_t              sel;
  logic              rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q, alu_in1_q, alu_in2_q;
  logic [3:0]        alu_op_q;

  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign req[0] = {bus.req0_in1, bus.req0_in2, bus.req0_op};
  assign req[1] = {bus.req1_in1, bus.req1_in2, bus.req1_op};

  always_comb begin
    gnt = vld[1] & ~vld[0];
    if (&vld && RR_EN) gnt = ~last_grant;
  end

  // Ready is gated by rst_n so it reads 0 while reset is held, even with valid up.
  always_comb begin
    rdy = '0;
    if (state == IDLE && rst_n) rdy[gnt] = vld[gnt];
  end

  assign sel = req[gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      op_bad      <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (|rdy) begin
          last_grant <= gnt;
          id_q       <= gnt;
          alu_in1_q  <= sel.in1;
          alu_in2_q  <= sel.in2;
          // An illegal opcode never reaches the ALU; the result is forced to 0 later.
          op_bad     <= sel.op > OP_LIM;
          alu_op_q   <= (sel.op > OP_LIM) ? 4'd0 : sel.op;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_err_q   <= op_bad;
          rsp_data_q  <= op_bad ? '0 : bus.alu_out;
          alu_in1_q   <= '0;
          alu_in2_q   <= '0;
          alu_op_q    <= '0;
          state       <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_id_q    <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.alu_op     = alu_op_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives a round-robin (inst 0) and a fixed-priority (inst 1) arbiter; a per-cycle
// reference model plus directed literal checks judge both.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         v   [2][2];
  logic [W-1:0] a   [2][2];
  logic [W-1:0] b   [2][2];
  logic [3:0]   o   [2][2];
  logic         rr  [2];
  logic         rdy_o [2][2];
  logic         rv [2], rid [2], rerr [2];
  logic [W-1:0] rdat [2], ai1 [2], ai2 [2];
  logic [3:0]   aop [2];

  int vectors = 0;
  int errs = 0;
  int nacc [2][2];

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] x, logic [W-1:0] y, logic [3:0] op);
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x << y[4:0];
      4'd6: return x >> y[4:0];
      4'd7: return $signed(x) >>> y[4:0];
      4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(string nm, int k, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, k, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    alu_share_if #(.DATA_W(W)) ifc ();
    alu_share_arbiter #(.DATA_W(W), .RR_EN(k == 0), .OP_MAX(9)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    assign ifc.req0_valid = v[k][0];
    assign ifc.req0_in1   = a[k][0];
    assign ifc.req0_in2   = b[k][0];
    assign ifc.req0_op    = o[k][0];
    assign ifc.req1_valid = v[k][1];
    assign ifc.req1_in1   = a[k][1];
    assign ifc.req1_in2   = b[k][1];
    assign ifc.req1_op    = o[k][1];
    assign ifc.rsp_ready  = rr[k];
    assign ifc.alu_out    = alu_fn(ifc.alu_in1, ifc.alu_in2, ifc.alu_op);
    assign rdy_o[k][0] = ifc.req0_ready;
    assign rdy_o[k][1] = ifc.req1_ready;
    assign rv[k]   = ifc.rsp_valid;
    assign rid[k]  = ifc.rsp_id;
    assign rerr[k] = ifc.rsp_err;
    assign rdat[k] = ifc.rsp_data;
    assign ai1[k]  = ifc.alu_in1;
    assign ai2[k]  = ifc.alu_in2;
    assign aop[k]  = ifc.alu_op;
  end

  // Reference model: ph = cycles into the current transaction (0 idle, 1 exec, 2 resp).
  int           ph [2];
  logic         mlast [2], mid [2], merr [2];
  logic [W-1:0] ma [2], mb [2], mdat [2];
  logic [3:0]   mo [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic eg, er0, er1;
      if (!rst_n) begin
        chk("rst_req0_ready", k, rdy_o[k][0], 0);
        chk("rst_req1_ready", k, rdy_o[k][1], 0);
        chk("rst_rsp_valid", k, rv[k], 0);
        chk("rst_rsp_data", k, rdat[k], 0);
        chk("rst_alu_in1", k, ai1[k], 0);
        chk("rst_alu_op", k, aop[k], 0);
        ph[k] = 0;
        mlast[k] = 1'b1;
      end else begin
        if (v[k][0] && v[k][1]) eg = (k == 0) ? ~mlast[k] : 1'b0;
        else eg = v[k][1];
        er0 = (ph[k] == 0) && v[k][0] && !eg;
        er1 = (ph[k] == 0) && v[k][1] && eg;
        chk("req0_ready", k, rdy_o[k][0], er0);
        chk("req1_ready", k, rdy_o[k][1], er1);
        chk("alu_in1", k, ai1[k], (ph[k] == 1) ? ma[k] : '0);
        chk("alu_in2", k, ai2[k], (ph[k] == 1) ? mb[k] : '0);
        chk("alu_op", k, aop[k], (ph[k] == 1 && mo[k] <= 4'd9) ? mo[k] : 4'd0);
        chk("rsp_valid", k, rv[k], ph[k] == 2);
        if (ph[k] == 2) begin
          chk("rsp_id", k, rid[k], mid[k]);
          chk("rsp_err", k, rerr[k], merr[k]);
          chk("rsp_data", k, rdat[k], mdat[k]);
        end
        case (ph[k])
          0: if (er0 || er1) begin
            mid[k] = eg; mlast[k] = eg;
            ma[k] = a[k][eg]; mb[k] = b[k][eg]; mo[k] = o[k][eg];
            ph[k] = 1;
          end
          1: begin
            merr[k] = mo[k] > 4'd9;
            mdat[k] = merr[k] ? '0 : alu_fn(ma[k], mb[k], mo[k]);
            ph[k] = 2;
          end
          default: if (rr[k]) ph[k] = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(int pv, int pr, int pbad, int n);
    logic acc [2][2];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          acc[k][p] = v[k][p] && rdy_o[k][p];
          if (acc[k][p]) nacc[k][p]++;
        end
      tick();
      for (int k = 0; k < 2; k++) begin
        rr[k] = $urandom_range(99) < pr;
        for (int p = 0; p < 2; p++) begin
          if (!v[k][p] || acc[k][p]) begin
            v[k][p] = $urandom_range(99) < pv;
            a[k][p] = $urandom;
            b[k][p] = ($urandom_range(1)) ? $urandom : W'($urandom_range(40));
            o[k][p] = ($urandom_range(99) < pbad) ? 4'($urandom_range(15, 10))
                                                   : 4'($urandom_range(9));
          end else if (pv < 100 && $urandom_range(99) < 3) begin
            v[k][p] = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    logic         gid  [4];
    logic [W-1:0] gdat [4];
    logic [W-1:0] xdat [4];
    logic [W-1:0] p0a [2], p0b [2], p1a [2], p1b [2];
    logic [3:0]   p0o [2], p1o [2];
    int got_n, i0, i1;
    logic acc0, acc1;

    for (int k = 0; k < 2; k++) begin
      rr[k] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        v[k][p] = 1'b0; a[k][p] = '0; b[k][p] = '0; o[k][p] = '0; nacc[k][p] = 0;
      end
    end
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rsp_id", 0, rid[0], 0);
    chk("reset_rsp_err", 0, rerr[0], 0);
    chk("reset_alu_in2", 0, ai2[0], 0);
    tick();
    rst_n = 1'b1;

    // Port 0 alone: 10 + 2, response two cycles after accept
    v[0][0] = 1'b1; a[0][0] = 32'd10; b[0][0] = 32'd2; o[0][0] = 4'd0;
    @(negedge clk); chk("t1_ready", 0, rdy_o[0][0], 1);
    tick(); v[0][0] = 1'b0;
    @(negedge clk); chk("t1_alu_in1", 0, ai1[0], 32'd10); chk("t1_alu_in2", 0, ai2[0], 32'd2);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", 0, rv[0], 1); chk("t1_rsp_data", 0, rdat[0], 32'd12);
    chk("t1_rsp_id", 0, rid[0], 0);   chk("t1_rsp_err", 0, rerr[0], 0);
    tick();

    // Illegal opcode 12
    v[0][0] = 1'b1; a[0][0] = 32'd5; b[0][0] = 32'd6; o[0][0] = 4'd12;
    @(negedge clk); chk("t4_ready", 0, rdy_o[0][0], 1);
    tick(); v[0][0] = 1'b0;
    @(negedge clk); chk("t4_alu_op", 0, aop[0], 4'd0);
    tick();
    @(negedge clk); chk("t4_rsp_err", 0, rerr[0], 1); chk("t4_rsp_data", 0, rdat[0], 0);
    tick();

    // Response backpressure: 7 - 1 held for 5 cycles while port 1 waits
    rr[0] = 1'b0;
    v[0][0] = 1'b1; a[0][0] = 32'd7; b[0][0] = 32'd1; o[0][0] = 4'd1;
    @(negedge clk);
    tick(); v[0][0] = 1'b0;
    v[0][1] = 1'b1; a[0][1] = 32'd20; b[0][1] = 32'd22; o[0][1] = 4'd1;
    @(negedge clk);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_rsp_valid", 0, rv[0], 1); chk("t5_rsp_data", 0, rdat[0], 32'd6);
      chk("t5_req1_ready", 0, rdy_o[0][1], 0);
      tick();
    end
    rr[0] = 1'b1;
    @(negedge clk); chk("t5_rsp_last", 0, rv[0], 1);
    tick();
    @(negedge clk); chk("t5_req1_ready_after", 0, rdy_o[0][1], 1); chk("t5_rsp_gone", 0, rv[0], 0);
    tick(); v[0][1] = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk); chk("t5_p1_data", 0, rdat[0], 32'hFFFF_FFFE); chk("t5_p1_id", 0, rid[0], 1);
    tick();

    // Reset pulse during EXEC
    v[0][0] = 1'b1; a[0][0] = 32'd1; b[0][0] = 32'd1; o[0][0] = 4'd0;
    tick(); v[0][0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_alu_in1", 0, ai1[0], 0); chk("t6_rsp_valid", 0, rv[0], 0);
    @(negedge clk);
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("t6_no_rsp", 0, rv[0], 0);
      tick();
    end

    // Both ports valid back-to-back on the round-robin instance
    p0a = '{32'hFFFF_FFFC, 32'd5}; p0b = '{32'd4, 32'd5};  p0o = '{4'd0, 4'd0};
    p1a = '{32'd3, 32'd7};         p1b = '{32'd10, 32'd2}; p1o = '{4'd1, 4'd2};
    xdat = '{32'd0, 32'hFFFF_FFF9, 32'd10, 32'd2};
    i0 = 0; i1 = 0; got_n = 0;
    v[0][0] = 1'b1; a[0][0] = p0a[0]; b[0][0] = p0b[0]; o[0][0] = p0o[0];
    v[0][1] = 1'b1; a[0][1] = p1a[0]; b[0][1] = p1b[0]; o[0][1] = p1o[0];
    for (int c = 0; c < 40 && got_n < 4; c++) begin
      @(negedge clk);
      acc0 = v[0][0] && rdy_o[0][0];
      acc1 = v[0][1] && rdy_o[0][1];
      if (rv[0]) begin gid[got_n] = rid[0]; gdat[got_n] = rdat[0]; got_n++; end
      tick();
      if (acc0) begin
        i0++;
        if (i0 < 2) begin a[0][0] = p0a[i0]; b[0][0] = p0b[i0]; o[0][0] = p0o[i0]; end
        else v[0][0] = 1'b0;
      end
      if (acc1) begin
        i1++;
        if (i1 < 2) begin a[0][1] = p1a[i1]; b[0][1] = p1b[i1]; o[0][1] = p1o[i1]; end
        else v[0][1] = 1'b0;
      end
    end
    chk("t2_count", 0, got_n, 4);
    for (int i = 0; i < 4 && i < got_n; i++) begin
      chk("t2_id", i, gid[i], i % 2);
      chk("t2_data", i, gdat[i], xdat[i]);
    end

    // Random traffic, then continuous contention, then sparse traffic
    rand_phase(50, 70, 10, 800);
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) nacc[k][p] = 0;
    rand_phase(100, 100, 0, 300);
    chk("t3_fixed_port1_grants", 1, nacc[1][1], 0);
    chk("t3_fixed_port0_active", 1, nacc[1][0] > 50, 1);
    chk("t3_rr_balance", 0, (nacc[0][0] - nacc[0][1] <= 1) && (nacc[0][1] - nacc[0][0] <= 1), 1);
    chk("t3_rr_active", 0, nacc[0][0] > 20, 1);
    rand_phase(30, 40, 20, 600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
